// File: rtl/ev20_pkg.sv
// ev20_pkg: shared constants and types for the EV20 program-counter controller.
//   PC_W / OFS_W / DEPTH : PC width, relative-offset width, return-stack depth
//   op_e                 : decoded flow-control operation codes
//   FC_*                 : fault-cause codes reported on fault_code
//   pc_state_e           : controller FSM states
//   nxt_sel_e            : next-PC source selection for pc_next
package ev20_pkg;

    localparam int PC_W  = 11;
    localparam int OFS_W = 10;
    localparam int DEPTH = 4;

    typedef enum logic [1:0] {
        OP_SEQ  = 2'b00,
        OP_JMP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_OVF  = 2'b01;
    localparam logic [1:0] FC_UNF  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CALL_ISSUE = 3'd1,
        ST_RET_ISSUE  = 3'd2,
        ST_LOAD       = 3'd3,
        ST_FAULT      = 3'd4
    } pc_state_e;

    typedef enum logic [1:0] {
        NXT_HOLD = 2'b00,
        NXT_INC  = 2'b01,
        NXT_REL  = 2'b10,
        NXT_STK  = 2'b11
    } nxt_sel_e;

endpackage

// File: rtl/pc_next.sv
// pc_next: combinational next-PC selection.
//   i_sel    : source select (hold / PC+1 / PC+zext(ofs) / stack PC)
//   i_pc     : current PC
//   i_ofs    : unsigned relative offset, zero-extended to PC_W
//   i_stk_pc : PC returned by the branch/return stack
//   o_pc     : selected next PC, arithmetic wraps modulo 2^PC_W
module pc_next
    import ev20_pkg::*;
#(
    parameter int P_PC_W  = PC_W,
    parameter int P_OFS_W = OFS_W
) (
    input  nxt_sel_e            i_sel,
    input  logic [P_PC_W-1:0]   i_pc,
    input  logic [P_OFS_W-1:0]  i_ofs,
    input  logic [P_PC_W-1:0]   i_stk_pc,
    output logic [P_PC_W-1:0]   o_pc
);

    logic [P_PC_W-1:0] w_ofs_zx;

    assign w_ofs_zx = {{(P_PC_W-P_OFS_W){1'b0}}, i_ofs};

    // Sums are kept at P_PC_W bits so the carry out is dropped (modulo wrap).
    always_comb begin
        o_pc = i_pc;
        case (i_sel)
            NXT_INC:  o_pc = i_pc + P_PC_W'(1);
            NXT_REL:  o_pc = i_pc + w_ofs_zx;
            NXT_STK:  o_pc = i_stk_pc;
            default:  o_pc = i_pc;
        endcase
    end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: EV20 program-counter controller and initiator side of the
// branch/return stack.
//   clk, rst            : clock, synchronous active-high reset
//   hold                : advance enable (1 = act), shared with the stack
//   op_valid/op/S       : offered operation and its offset
//   op_ready            : controller can accept an operation
//   PC, OLD_PC          : current PC (OLD_PC is the value pushed on CALL)
//   branch, ret         : registered push / pop strobes to the stack
//   stk_pc, stk_level   : stack NEW_PC and fill level
//   fault, fault_code   : sticky overflow/underflow fault
module pc_ctrl
    import ev20_pkg::*;
#(
    parameter int P_PC_W  = PC_W,
    parameter int P_OFS_W = OFS_W,
    parameter int P_DEPTH = DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic                op_valid,
    input  logic [1:0]          op,
    input  logic [P_OFS_W-1:0]  S,
    output logic                op_ready,
    output logic [P_PC_W-1:0]   PC,
    output logic                branch,
    output logic                ret,
    output logic [P_PC_W-1:0]   OLD_PC,
    input  logic [P_PC_W-1:0]   stk_pc,
    input  logic [2:0]          stk_level,
    output logic                fault,
    output logic [1:0]          fault_code
);

    pc_state_e          r_state;
    logic [P_PC_W-1:0]  r_pc;
    logic               r_branch;
    logic               r_ret;
    logic               r_fault;
    logic [1:0]         r_fault_code;

    op_e                w_op;
    logic               w_accept;
    nxt_sel_e           w_sel;
    logic [P_PC_W-1:0]  w_pc_next;

    assign w_op     = op_e'(op);
    assign op_ready = (r_state == ST_IDLE) & ~rst;
    assign w_accept = op_valid & op_ready & hold;

    // PC only moves on an accepted SEQ/JMP or on the LOAD edge; CALL/RET
    // keep it frozen so OLD_PC stays stable while the stack samples it.
    always_comb begin
        w_sel = NXT_HOLD;
        if (w_accept) begin
            if (w_op == OP_SEQ)      w_sel = NXT_INC;
            else if (w_op == OP_JMP) w_sel = NXT_REL;
        end else if (hold && r_state == ST_LOAD) begin
            w_sel = NXT_STK;
        end
    end

    pc_next #(
        .P_PC_W  (P_PC_W),
        .P_OFS_W (P_OFS_W)
    ) u_pc_next (
        .i_sel    (w_sel),
        .i_pc     (r_pc),
        .i_ofs    (S),
        .i_stk_pc (stk_pc),
        .o_pc     (w_pc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= '0;
            r_branch     <= 1'b0;
            r_ret        <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
        end else if (hold) begin
            r_pc <= w_pc_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_CALL: begin
                                if (stk_level >= 3'(P_DEPTH)) begin
                                    r_state      <= ST_FAULT;
                                    r_fault      <= 1'b1;
                                    r_fault_code <= FC_OVF;
                                end else begin
                                    r_state  <= ST_CALL_ISSUE;
                                    r_branch <= 1'b1;
                                end
                            end
                            OP_RET: begin
                                if (stk_level == 3'd0) begin
                                    r_state      <= ST_FAULT;
                                    r_fault      <= 1'b1;
                                    r_fault_code <= FC_UNF;
                                end else begin
                                    r_state <= ST_RET_ISSUE;
                                    r_ret   <= 1'b1;
                                end
                            end
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                end
                // The stack samples the strobe on this same hold=1 edge.
                ST_CALL_ISSUE: begin
                    r_branch <= 1'b0;
                    r_state  <= ST_LOAD;
                end
                ST_RET_ISSUE: begin
                    r_ret   <= 1'b0;
                    r_state <= ST_LOAD;
                end
                ST_LOAD:  r_state <= ST_IDLE;
                ST_FAULT: r_state <= ST_FAULT;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign PC         = r_pc;
    assign OLD_PC     = r_pc;
    assign branch     = r_branch;
    assign ret        = r_ret;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        op_valid;
    logic [1:0]  op;
    logic [9:0]  S;
    logic        op_ready;
    logic [10:0] PC;
    logic        branch;
    logic        ret;
    logic [10:0] OLD_PC;
    logic [10:0] stk_pc;
    logic [2:0]  stk_level;
    logic        fault;
    logic [1:0]  fault_code;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .op_valid   (op_valid),
        .op         (op),
        .S          (S),
        .op_ready   (op_ready),
        .PC         (PC),
        .branch     (branch),
        .ret        (ret),
        .OLD_PC     (OLD_PC),
        .stk_pc     (stk_pc),
        .stk_level  (stk_level),
        .fault      (fault),
        .fault_code (fault_code)
    );

    // Behavioural 4-deep branch/return stack, sampled on hold=1 edges.
    logic        m_clr;
    logic [2:0]  m_lvl;
    logic [10:0] m_npc;
    logic [10:0] m_stk [0:3];

    assign stk_level = m_lvl;
    assign stk_pc    = m_npc;

    always @(posedge clk) begin
        if (m_clr) begin
            m_lvl <= 3'd0;
            m_npc <= 11'd0;
        end else if (hold) begin
            if (branch && m_lvl < 3'd4) begin
                m_stk[m_lvl[1:0]] <= OLD_PC;
                m_lvl <= m_lvl + 3'd1;
                m_npc <= OLD_PC + {1'b0, S};
            end else if (ret && m_lvl > 3'd0) begin
                m_npc <= m_stk[2'(m_lvl - 3'd1)] + 11'd1;
                m_lvl <= m_lvl - 3'd1;
            end
        end
    end

    localparam logic [1:0] SEQ = 2'b00, JMP = 2'b01, CALL = 2'b10, RET = 2'b11;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},     32'(PC), 32'h0);
        chk({tag, "_branch"}, 32'(branch), 32'h0);
        chk({tag, "_ret"},    32'(ret), 32'h0);
        chk({tag, "_fault"},  32'(fault), 32'h0);
        chk({tag, "_fcode"},  32'(fault_code), 32'h0);
    endtask

    // Reset DUT and model stack together, leave rst low afterwards.
    task automatic do_reset();
        rst = 1'b1; m_clr = 1'b1; op_valid = 1'b0; hold = 1'b1;
        tick();
        rst = 1'b0; m_clr = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [9:0] s);
        op = o; S = s; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b1; op_valid = 1'b0; op = SEQ; S = '0; m_clr = 1'b1;
        tick();
        tick();
        chk("rst_ready", 32'(op_ready), 32'h0);
        chk_reset_vals("rst");
        rst = 1'b0; m_clr = 1'b0;
        #1;
        chk("ready_after_rst", 32'(op_ready), 32'h1);

        // SEQ x3
        op = SEQ; op_valid = 1'b1;
        tick(); chk("seq1", 32'(PC), 32'h1); chk("seq1_rdy", 32'(op_ready), 32'h1);
        tick(); chk("seq2", 32'(PC), 32'h2); chk("seq2_rdy", 32'(op_ready), 32'h1);
        tick(); chk("seq3", 32'(PC), 32'h3); chk("seq3_rdy", 32'(op_ready), 32'h1);
        op_valid = 1'b0;

        // hold=0 blocks acceptance
        hold = 1'b0; op = SEQ; op_valid = 1'b1;
        tick(); chk("hold0_seq", 32'(PC), 32'h3);
        op_valid = 1'b0; hold = 1'b1;

        // JMP with wrap
        do_reset();
        issue(JMP, 10'h3FF); chk("jmp_3ff", 32'(PC), 32'h3FF);
        issue(JMP, 10'h3FF); chk("jmp_7fe", 32'(PC), 32'h7FE);
        issue(JMP, 10'h005); chk("jmp_wrap", 32'(PC), 32'h003);

        do_reset();
        issue(JMP, 10'h100); chk("jmp_100", 32'(PC), 32'h100);
        issue(JMP, 10'h3FF); chk("jmp_4ff", 32'(PC), 32'h4FF);

        // CALL then RET
        do_reset();
        issue(JMP, 10'h020);
        issue(CALL, 10'h010);
        chk("call_branch", 32'(branch), 32'h1);
        chk("call_oldpc",  32'(OLD_PC), 32'h020);
        chk("call_pc_hold", 32'(PC), 32'h020);
        chk("call_notrdy", 32'(op_ready), 32'h0);
        tick();
        chk("call_branch_low", 32'(branch), 32'h0);
        chk("call_load_pc", 32'(PC), 32'h020);
        tick();
        chk("call_newpc", 32'(PC), 32'h030);
        chk("call_rdy", 32'(op_ready), 32'h1);

        issue(RET, 10'h000);
        chk("ret_strobe", 32'(ret), 32'h1);
        chk("ret_nobranch", 32'(branch), 32'h0);
        tick();
        chk("ret_low", 32'(ret), 32'h0);
        tick();
        chk("ret_newpc", 32'(PC), 32'h021);

        // CALL with hold 1,0,0,1,1
        S = 10'h010;
        issue(CALL, 10'h010);
        chk("hc_branch_a", 32'(branch), 32'h1);
        hold = 1'b0;
        tick(); chk("hc_branch_b", 32'(branch), 32'h1); chk("hc_pc_b", 32'(PC), 32'h021);
        tick(); chk("hc_branch_c", 32'(branch), 32'h1); chk("hc_rdy_c", 32'(op_ready), 32'h0);
        hold = 1'b1;
        tick(); chk("hc_branch_d", 32'(branch), 32'h0); chk("hc_pc_d", 32'(PC), 32'h021);
        tick(); chk("hc_pc_e", 32'(PC), 32'h031); chk("hc_rdy_e", 32'(op_ready), 32'h1);
        tick(); chk("hc_pc_once", 32'(PC), 32'h031);

        // Overflow on fifth CALL
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(CALL, 10'h001);
            tick();
            tick();
        end
        chk("ovf_pre_pc", 32'(PC), 32'h4);
        issue(CALL, 10'h001);
        chk("ovf_fault", 32'(fault), 32'h1);
        chk("ovf_code", 32'(fault_code), 32'h1);
        chk("ovf_nobranch", 32'(branch), 32'h0);
        chk("ovf_pc", 32'(PC), 32'h4);
        chk("ovf_rdy", 32'(op_ready), 32'h0);
        op = SEQ; op_valid = 1'b1;
        tick();
        chk("ovf_absorb_pc", 32'(PC), 32'h4);
        chk("ovf_absorb_br", 32'(branch), 32'h0);
        op_valid = 1'b0;
        rst = 1'b1; m_clr = 1'b1;
        tick();
        chk_reset_vals("ovf_rst");
        rst = 1'b0; m_clr = 1'b0;
        #1;
        chk("ovf_rst_rdy", 32'(op_ready), 32'h1);

        // Underflow
        issue(RET, 10'h000);
        chk("unf_fault", 32'(fault), 32'h1);
        chk("unf_code", 32'(fault_code), 32'h2);
        chk("unf_noret", 32'(ret), 32'h0);
        tick();
        chk("unf_noret2", 32'(ret), 32'h0);

        // Reset during RET_ISSUE
        do_reset();
        issue(CALL, 10'h010);
        tick();
        tick();
        chk("rr_pc", 32'(PC), 32'h010);
        issue(RET, 10'h000);
        chk("rr_ret", 32'(ret), 32'h1);
        rst = 1'b1;
        tick();
        chk("rr_ret_low", 32'(ret), 32'h0);
        chk("rr_pc0", 32'(PC), 32'h0);
        chk("rr_rdy_rst", 32'(op_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("rr_rdy", 32'(op_ready), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter controller for the EV20 core: accepts decoded flow-control operations (sequential, relative jump, call, return), advances the 11-bit PC, and acts as the initiator side of the 4-deep branch/return stack, driving its `branch`/`ret` strobes and loading the PC from the stack's `NEW_PC`. It checks stack depth before every call and return, and it latches a sticky fault on overflow or underflow.

## Interface
- `PC_W`, 11, PC width.
- `OFS_W`, 10, relative-offset width (unsigned, zero-extended).
- `DEPTH`, 4, return-stack depth. It must match the stack instance.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `hold`  in  1  core advance enable (1 = act). It is routed to the stack's `hold` unchanged.
- `op_valid`  in  1  operation offered this cycle.
- `op`  in  2  operation code: 00 SEQ, 01 JMP, 10 CALL, 11 RET.
- `S`  in  OFS_W  offset for JMP/CALL.
- `op_ready`  out  1  controller can accept an operation.
- `PC`  out  PC_W  current program counter.
- `branch`  out  1  push strobe to the stack.
- `ret`  out  1  pop strobe to the stack.
- `OLD_PC`  out  PC_W  PC value pushed on CALL. It equals `PC`.
- `stk_pc`  in  PC_W  stack `NEW_PC`.
- `stk_level`  in  3  stack `level`.
- `fault`  out  1  sticky stack fault.
- `fault_code`  out  2  fault cause: 00 none, 01 overflow, 10 underflow.

## Operation
- FSM states:
  - IDLE
  - CALL_ISSUE
  - RET_ISSUE
  - LOAD
  - FAULT
- `op_ready` = (state==IDLE) & !rst.
- An operation is accepted on a rising edge when `op_valid & op_ready & hold`. With `hold` = 0, nothing is accepted and every register holds.
- SEQ: PC <= PC+1, modulo 2^PC_W. Stay in IDLE.
- JMP: PC <= PC + zext(S), modulo 2^PC_W. Stay in IDLE.
- CALL with `stk_level` < DEPTH: go to CALL_ISSUE with `branch`=1. PC holds, so `OLD_PC` is stable for the stack.
- CALL with `stk_level` == DEPTH: go to FAULT, fault_code=01. No strobe is issued and PC holds.
- RET with `stk_level` > 0: go to RET_ISSUE with `ret`=1.
- RET with `stk_level` == 0: go to FAULT, fault_code=10. No strobe is issued.
- CALL_ISSUE / RET_ISSUE:
  - The strobe stays asserted until an edge with `hold`=1. The stack samples on that same edge.
  - On that edge, the strobe deasserts and the FSM goes to LOAD.
- LOAD, on an edge with `hold`=1: PC <= `stk_pc` and the FSM returns to IDLE.
  - For a call, `stk_pc` = OLD_PC + S, computed by the stack.
  - For a return, `stk_pc` = stacked PC + 1.
- FAULT is absorbing until `rst`: `op_ready`=0, PC frozen, strobes 0.
- `branch` and `ret` are registered and are never high together.

## Timing
- On reset: PC=0, `branch`=0, `ret`=0, `fault`=0, `fault_code`=00, state=IDLE. `op_ready`=0 while `rst` is high and 1 on the first cycle after.
- Reset mid-operation (any state) returns everything to the reset values on that edge. The stack is not reset by this block.
- SEQ/JMP latency: 1 cycle. The new PC is visible after the accepting edge.
- CALL/RET latency, with `hold` held at 1: 3 edges.
  - Accept edge → strobe high.
  - Stack-sample edge → strobe low, state LOAD.
  - Load edge → new PC, `op_ready`=1.
- `stk_level` is sampled only on the accept edge.
- `op_valid` while `op_ready`=0 is ignored. The source must hold the operation until it is accepted.

## Structure
- Shared package `ev20_pkg` holds:
  - `PC_W`, `OFS_W`, `DEPTH`
  - the op-code enum (SEQ/JMP/CALL/RET)
  - the fault-code constants
  - the FSM state enum
- One sub-module, `pc_next`: combinational next-PC selection (PC+1, PC+zext(S), `stk_pc`, hold) with modulo wrap.

## Test plan
- Reset, then SEQ ×3 with `hold`=1 → PC = 0,1,2,3; `op_ready`=1 throughout.
- PC=0x7FE, JMP S=0x005 → PC=0x003 (wrap). PC=0x100, JMP S=0x3FF → PC=0x4FF.
- PC=0x020, level=0, CALL S=0x010:
  - `branch` high 1 cycle with `OLD_PC`=0x020.
  - After the model stack updates, PC=0x030 after 3 edges.
  - Then RET → `ret` 1 cycle, PC=0x021.
- CALL in IDLE with `hold` toggled 1,0,0,1,1 over the following edges → `branch` stays high across the `hold`=0 cycles and drops only after the first `hold`=1 edge; PC loads exactly once.
- CALL ×4 (level reaches 4), then a fifth CALL:
  - `fault`=1, `fault_code`=01, no `branch` pulse, PC unchanged, `op_ready`=0.
  - `rst` → all outputs return to reset values.
- RET at level 0 → `fault_code`=10, no `ret` pulse. Separately, assert `rst` during RET_ISSUE → `ret`=0, PC=0 on the next edge.
